// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM-stage data-memory access controller, sitting between the EX/MEM and
// MEM/WB pipeline registers. Issues exactly one dcache request per load or
// store, aligns sub-word store data onto byte lanes, and extracts and extends
// load data. When the dcache completes while the pipeline is frozen, the
// result is held and the request is not reissued until the pipeline advances.
//
// Ports
//   CLK, nRST       clock (rising edge), asynchronous active-low reset
//   memren_mem      load present in MEM
//   memwen_mem      store present in MEM
//   funct3_mem      access size/signedness (b, h, w, bu, hu)
//   addr_mem        byte address from the ALU
//   storedata_mem   right-aligned store data (rs2)
//   pipe_advance    all stage registers capture this cycle
//   dhit            dcache completes the current request this cycle
//   dmemload        raw dcache word, valid with dhit
//   dmemREN/WEN     dcache read/write requests
//   dmemaddr        word-aligned dcache address
//   dmemstore       lane-replicated store data
//   dmembyteen      store byte enables (0 when not writing)
//   dmemload_mem    extended load result to MEM/WB
//   mem_stall       MEM stage still waiting on the dcache
//   misalign_err    illegal or misaligned access present
//   stall_cnt       saturating count of stalled cycles
module mem_stage_ctrl #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 32
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              memren_mem,
   input  logic              memwen_mem,
   input  logic [2:0]        funct3_mem,
   input  logic [DATA_W-1:0] addr_mem,
   input  logic [DATA_W-1:0] storedata_mem,
   input  logic              pipe_advance,
   input  logic              dhit,
   input  logic [DATA_W-1:0] dmemload,
   output logic              dmemREN,
   output logic              dmemWEN,
   output logic [DATA_W-1:0] dmemaddr,
   output logic [DATA_W-1:0] dmemstore,
   output logic [3:0]        dmembyteen,
   output logic [DATA_W-1:0] dmemload_mem,
   output logic              mem_stall,
   output logic              misalign_err,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   state_t            next_state;
   logic              access;
   logic              bad_access;
   logic              op;
   logic [7:0]        load_byte;
   logic [15:0]       load_half;
   logic [DATA_W-1:0] load_ext;
   logic [3:0]        lane_en;
   logic [DATA_W-1:0] lane_data;
   logic [DATA_W-1:0] held_load;

   assign access       = memren_mem | memwen_mem;
   assign misalign_err = access & bad_access;
   assign op           = access & ~bad_access;
   assign dmemaddr     = {addr_mem[DATA_W-1:2], 2'b00};

   // Classify the access: reserved funct3 codes, unsigned store encodings
   // and unaligned halfword/word addresses are all rejected.
   always_comb begin
      bad_access = 1'b0;
      case (funct3_mem)
         3'b000:  bad_access = 1'b0;
         3'b001:  bad_access = addr_mem[0];
         3'b010:  bad_access = |addr_mem[1:0];
         3'b100:  bad_access = memwen_mem;
         3'b101:  bad_access = memwen_mem | addr_mem[0];
         default: bad_access = 1'b1;
      endcase
   end

   // Extract the addressed byte/half from the raw word and extend it.
   // funct3[2] marks the unsigned variants.
   always_comb begin
      load_byte = dmemload[{addr_mem[1:0], 3'b000} +: 8];
      load_half = addr_mem[1] ? dmemload[31:16] : dmemload[15:0];
      case (funct3_mem)
         3'b000:  load_ext = {{24{load_byte[7]}}, load_byte};
         3'b100:  load_ext = {24'h000000, load_byte};
         3'b001:  load_ext = {{16{load_half[15]}}, load_half};
         3'b101:  load_ext = {16'h0000, load_half};
         default: load_ext = dmemload;
      endcase
   end

   // Replicate store data across lanes so the byte enables alone pick the
   // destination bytes in the cache line.
   always_comb begin
      case (funct3_mem)
         3'b000: begin
            lane_en   = 4'b0001 << addr_mem[1:0];
            lane_data = {4{storedata_mem[7:0]}};
         end
         3'b001: begin
            lane_en   = addr_mem[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{storedata_mem[15:0]}};
         end
         default: begin
            lane_en   = 4'b1111;
            lane_data = storedata_mem;
         end
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   // Next-state logic. DONE means the access has completed but the pipeline
   // has not yet moved it on, so nothing may be reissued from there.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (op && dhit && !pipe_advance) next_state = DONE;
            else if (op && !dhit)            next_state = BUSY;
         end
         BUSY: begin
            if (dhit && pipe_advance)        next_state = IDLE;
            else if (dhit && !pipe_advance)  next_state = DONE;
         end
         DONE: begin
            if (pipe_advance)                next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic. Requests are gated with nRST so an in-flight request
   // drops the instant reset asserts rather than at the next clock edge.
   always_comb begin
      dmemREN      = 1'b0;
      dmemWEN      = 1'b0;
      dmembyteen   = 4'b0000;
      dmemstore    = lane_data;
      mem_stall    = 1'b0;
      dmemload_mem = '0;
      if (nRST && op && state != DONE) begin
         dmemREN   = memren_mem;
         dmemWEN   = memwen_mem;
         mem_stall = ~dhit;
      end
      if (dmemWEN) dmembyteen = lane_en;
      if (state == DONE)                   dmemload_mem = held_load;
      else if (dhit && memren_mem && op)   dmemload_mem = load_ext;
   end

   // Capture the extended load result on the way into DONE so it survives
   // the dcache moving on to other data while the pipeline is frozen.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         held_load <= '0;
      end else if (next_state == DONE && state != DONE) begin
         held_load <= memren_mem ? load_ext : '0;
      end
   end

   // Stall-cycle performance counter, saturating at all-ones.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt <= '0;
      end else if (mem_stall && stall_cnt != {CNT_W{1'b1}}) begin
         stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl. Completed dcache transactions are
// checked by a scoreboard monitor; per-cycle control behaviour (stalls,
// request gating, held data, reset) is checked inline by the stimulus thread.
module tb_mem_stage_ctrl;

   typedef struct {
      logic        is_store;
      logic [31:0] addr;
      logic [31:0] load_val;
      logic [3:0]  byteen;
      logic [31:0] store_val;
   } exp_t;

   logic        CLK;
   logic        nRST;
   logic        memren_mem;
   logic        memwen_mem;
   logic [2:0]  funct3_mem;
   logic [31:0] addr_mem;
   logic [31:0] storedata_mem;
   logic        pipe_advance;
   logic        dhit;
   logic [31:0] dmemload;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [3:0]  dmembyteen;
   logic [31:0] dmemload_mem;
   logic        mem_stall;
   logic        misalign_err;
   logic [31:0] stall_cnt;

   exp_t sb_queue[$];
   exp_t mon_exp;
   int   checks = 0;
   int   errors = 0;
   int   wen_count;

   mem_stage_ctrl #(.DATA_W(32), .CNT_W(32)) dut (
      .CLK(CLK),
      .nRST(nRST),
      .memren_mem(memren_mem),
      .memwen_mem(memwen_mem),
      .funct3_mem(funct3_mem),
      .addr_mem(addr_mem),
      .storedata_mem(storedata_mem),
      .pipe_advance(pipe_advance),
      .dhit(dhit),
      .dmemload(dmemload),
      .dmemREN(dmemREN),
      .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr),
      .dmemstore(dmemstore),
      .dmembyteen(dmembyteen),
      .dmemload_mem(dmemload_mem),
      .mem_stall(mem_stall),
      .misalign_err(misalign_err),
      .stall_cnt(stall_cnt)
   );

   // Free-running clock, period 10.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Drive one cycle of MEM-stage inputs just after the rising edge.
   task automatic applyStimulus(input logic ren, input logic wen,
                                input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic hit,
                                input logic adv, input logic [31:0] load);
      @(posedge CLK);
      #1;
      memren_mem    = ren;
      memwen_mem    = wen;
      funct3_mem    = f3;
      addr_mem      = addr;
      storedata_mem = sd;
      dhit          = hit;
      pipe_advance  = adv;
      dmemload      = load;
   endtask

   task automatic pushExpect(input logic is_store, input logic [31:0] addr,
                             input logic [31:0] load_val, input logic [3:0] be,
                             input logic [31:0] store_val);
      exp_t e;
      e.is_store  = is_store;
      e.addr      = addr;
      e.load_val  = load_val;
      e.byteen    = be;
      e.store_val = store_val;
      sb_queue.push_back(e);
   endtask

   // Scoreboard monitor: a dcache completion is a request with dhit.
   always @(negedge CLK) begin
      if (nRST && dhit && (dmemREN || dmemWEN)) begin
         if (sb_queue.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedAccess actual=%h expected=none", dmemaddr);
         end else begin
            mon_exp = sb_queue.pop_front();
            checkOutput("sbAddr", dmemaddr, mon_exp.addr);
            checkOutput("sbWen", {31'd0, dmemWEN}, {31'd0, mon_exp.is_store});
            checkOutput("sbByteen", {28'd0, dmembyteen}, {28'd0, mon_exp.byteen});
            if (mon_exp.is_store) checkOutput("sbStore", dmemstore, mon_exp.store_val);
            else                  checkOutput("sbLoad", dmemload_mem, mon_exp.load_val);
         end
      end
   end

   typedef struct {
      logic        ren;
      logic        wen;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] sd;
      logic [31:0] load;
      logic [31:0] exp_load;
      logic [3:0]  exp_be;
      logic [31:0] exp_store;
   } vec_t;

   vec_t hit_vecs[7];

   initial begin
      hit_vecs[0] = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 32'h1234_5678, 4'b0000, 32'h0};
      hit_vecs[1] = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 32'hFFFF_80FF, 4'b0000, 32'h0};
      hit_vecs[2] = '{1'b1, 1'b0, 3'b100, 32'h101, 32'h0, 32'h80FF_1234, 32'h0000_0012, 4'b0000, 32'h0};
      hit_vecs[3] = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 32'h80FF_9234, 32'h0000_9234, 4'b0000, 32'h0};
      hit_vecs[4] = '{1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 32'h0, 32'h0, 4'b0010, 32'h7878_7878};
      hit_vecs[5] = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFE_F00D, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D};
      hit_vecs[6] = '{1'b0, 1'b1, 3'b001, 32'h200, 32'h1111_ABCD, 32'h0, 32'h0, 4'b0011, 32'hABCD_ABCD};

      nRST = 1'b0;
      memren_mem = 1'b0; memwen_mem = 1'b0; funct3_mem = 3'b000;
      addr_mem = 32'h0; storedata_mem = 32'h0; pipe_advance = 1'b1;
      dhit = 1'b0; dmemload = 32'h0;

      // Reset state.
      @(negedge CLK);
      @(negedge CLK);
      checkOutput("rstRen", {31'd0, dmemREN}, 32'd0);
      checkOutput("rstWen", {31'd0, dmemWEN}, 32'd0);
      checkOutput("rstByteen", {28'd0, dmembyteen}, 32'd0);
      checkOutput("rstLoad", dmemload_mem, 32'd0);
      checkOutput("rstStall", {31'd0, mem_stall}, 32'd0);
      checkOutput("rstMisalign", {31'd0, misalign_err}, 32'd0);
      checkOutput("rstStallCnt", stall_cnt, 32'd0);
      @(posedge CLK);
      #1 nRST = 1'b1;

      // Same-cycle hits with the pipeline advancing: never stall.
      for (int i = 0; i < 7; i++) begin
         pushExpect(hit_vecs[i].wen, {hit_vecs[i].addr[31:2], 2'b00},
                    hit_vecs[i].exp_load, hit_vecs[i].exp_be, hit_vecs[i].exp_store);
         applyStimulus(hit_vecs[i].ren, hit_vecs[i].wen, hit_vecs[i].f3, hit_vecs[i].addr,
                       hit_vecs[i].sd, 1'b1, 1'b1, hit_vecs[i].load);
         @(negedge CLK);
         checkOutput("hitNoStall", {31'd0, mem_stall}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);
      checkOutput("hitStallCnt", stall_cnt, 32'd0);

      // lb 0x103 missing for three cycles.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b0, 1'b0, 32'h0);
         @(negedge CLK);
         checkOutput("missStall", {31'd0, mem_stall}, 32'd1);
         checkOutput("missRen", {31'd0, dmemREN}, 32'd1);
      end
      pushExpect(1'b0, 32'h100, 32'hFFFF_FF80, 4'b0000, 32'h0);
      applyStimulus(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1'b1, 1'b1, 32'h80FF_1234);
      @(negedge CLK);
      checkOutput("missHitStall", {31'd0, mem_stall}, 32'd0);
      checkOutput("missStallCnt", stall_cnt, 32'd3);
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

      // sh 0x202 hit while frozen: one WEN, then DONE until advance.
      wen_count = 0;
      pushExpect(1'b1, 32'h200, 32'h0, 4'b1100, 32'hABCD_ABCD);
      applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1'b1, 1'b0, 32'h0);
      @(negedge CLK);
      if (dmemWEN) wen_count++;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 1'b0, (i == 5), 32'h0);
         @(negedge CLK);
         if (dmemWEN) wen_count++;
         checkOutput("doneByteen", {28'd0, dmembyteen}, 32'd0);
         checkOutput("doneStall", {31'd0, mem_stall}, 32'd0);
      end
      checkOutput("storeWenCount", wen_count, 32'd1);
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

      // Illegal / misaligned accesses.
      applyStimulus(1'b1, 1'b0, 3'b101, 32'h101, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
      @(negedge CLK);
      checkOutput("lhuMisalign", {31'd0, misalign_err}, 32'd1);
      checkOutput("lhuRen", {31'd0, dmemREN}, 32'd0);
      checkOutput("lhuStall", {31'd0, mem_stall}, 32'd0);
      checkOutput("lhuLoad", dmemload_mem, 32'd0);
      applyStimulus(1'b0, 1'b1, 3'b100, 32'h200, 32'h55, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);
      checkOutput("sbuMisalign", {31'd0, misalign_err}, 32'd1);
      checkOutput("sbuWen", {31'd0, dmemWEN}, 32'd0);
      applyStimulus(1'b0, 1'b1, 3'b010, 32'h302, 32'h55, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);
      checkOutput("swMisalign", {31'd0, misalign_err}, 32'd1);
      checkOutput("swByteen", {28'd0, dmembyteen}, 32'd0);

      // lbu 0x102 hit while frozen: result held although dmemload changes.
      pushExpect(1'b0, 32'h100, 32'h0000_00FF, 4'b0000, 32'h0);
      applyStimulus(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 1'b1, 1'b0, 32'h80FF_1234);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 3'b100, 32'h102, 32'h0, 1'b0, (i == 3), 32'hDEAD_BEEF);
         @(negedge CLK);
         checkOutput("heldLoad", dmemload_mem, 32'h0000_00FF);
         checkOutput("heldRen", {31'd0, dmemREN}, 32'd0);
      end
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);

      // Reset asserted during BUSY.
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
      @(negedge CLK);
      checkOutput("busyStall", {31'd0, mem_stall}, 32'd1);
      #2 nRST = 1'b0;
      #1;
      checkOutput("rstBusyRen", {31'd0, dmemREN}, 32'd0);
      checkOutput("rstBusyStall", {31'd0, mem_stall}, 32'd0);
      memren_mem = 1'b0;
      pipe_advance = 1'b1;
      @(posedge CLK);
      #1 nRST = 1'b1;
      @(negedge CLK);
      checkOutput("postRstCnt", stall_cnt, 32'd0);
      checkOutput("postRstLoad", dmemload_mem, 32'd0);
      checkOutput("postRstRen", {31'd0, dmemREN}, 32'd0);
      // A fresh hit completes immediately, so the FSM is back in IDLE.
      pushExpect(1'b0, 32'h500, 32'h0BAD_F00D, 4'b0000, 32'h0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D);
      @(negedge CLK);
      checkOutput("postRstStall", {31'd0, mem_stall}, 32'd0);
      applyStimulus(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);
      checkOutput("postRstHeld", dmemload_mem, 32'h0BAD_F00D);
      applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0);
      @(negedge CLK);

      checkOutput("sbEmpty", sb_queue.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
